// File: rtl/pin_input_reader.sv
// ============================================================================
//  Module   : pin_input_reader
//  Brief    : Synchronises, glitch-filters and edge-detects a shared tristate
//             net; holds one edge event under a valid/ack handshake.
//  Option   : PIN_READER_TIMESTAMP_EN adds a free-running timestamp that is
//             captured into evtTime with each loaded event.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pin_input_reader #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 3,
  parameter int TS_W          = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pinIn,
  input  logic            en,
  output logic            level,
  output logic            rise,
  output logic            fall,
  output logic            evtValid,
  output logic            evtRise,
  input  logic            evtAck,
  output logic            ovr,
  input  logic            ovrClr
`ifdef PIN_READER_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0] evtTime
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILTER_CYCLES - 1);

  if ((FILTER_CYCLES < 1) || (FILTER_CYCLES > ((1 << CNT_W) - 1)) || (TS_W < 1)) begin : g_param_check
    $error("pin_input_reader: FILTER_CYCLES must be 1..2^CNT_W-1 and TS_W >= 1");
  end

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_rise_q, evt_rise_d;
  logic             ovr_q, ovr_d;
  logic             evt_load_w;
  logic             edge_w;

  // Filter: a new level is accepted only after FILTER_CYCLES consecutive mismatching samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en && (s2_q != level_q)) begin
      if (cnt_q == c_cnt_last) begin
        level_d = s2_q;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign edge_w = rise_q | fall_q;

  // An edge loads a fresh event when the slot is free or being acked this cycle.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_rise_d  = evt_rise_q;
    evt_load_w  = 1'b0;
    ovr_d       = ovrClr ? 1'b0 : ovr_q;
    if (edge_w) begin
      if (!evt_valid_q || evtAck) begin
        evt_valid_d = 1'b1;
        evt_rise_d  = rise_q;
        evt_load_w  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (evtAck && evt_valid_q) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_rise_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      s1_q        <= pinIn;
      s2_q        <= s1_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      evt_valid_q <= evt_valid_d;
      evt_rise_q  <= evt_rise_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef PIN_READER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] evt_time_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      evt_time_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (evt_load_w) begin
        evt_time_q <= ts_q;
      end
    end
  end

  assign evtTime = evt_time_q;
`else
  logic unused_load_w;
  assign unused_load_w = evt_load_w;
`endif

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign evtValid = evt_valid_q;
  assign evtRise  = evt_rise_q;
  assign ovr      = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_pin_input_reader.sv
// Testbench for pin_input_reader: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the pin reader.
`default_nettype none

module tb_pin_input_reader;

  localparam int FILT = 4;
  localparam int TSW  = 16;

  logic clk = 1'b0;
  logic rst, pinIn, en, evtAck, ovrClr;
  logic level, rise, fall, evtValid, evtRise, ovr;
`ifdef PIN_READER_TIMESTAMP_EN
  logic [TSW-1:0] evtTime;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pin_input_reader #(.FILTER_CYCLES(FILT), .CNT_W(3), .TS_W(TSW)) dut (
    .clk(clk), .rst(rst), .pinIn(pinIn), .en(en),
    .level(level), .rise(rise), .fall(fall),
    .evtValid(evtValid), .evtRise(evtRise), .evtAck(evtAck),
    .ovr(ovr), .ovrClr(ovrClr)
`ifdef PIN_READER_TIMESTAMP_EN
    , .evtTime(evtTime)
`endif
  );

  // Reference model state: synchroniser samples, accepted level, length of the
  // current run of enabled mismatching samples, edge pulses, single event slot.
  bit m_s1, m_s2, m_level, m_rise, m_fall, m_ovr;
  int m_run;
  bit pend_q[$];
  int m_ts, m_evtime;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ovr_set;
    bit was_rise, was_edge;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_ovr = 0;
      m_run = 0; pend_q.delete(); m_ts = 0; m_evtime = 0;
      return;
    end
    ovr_set  = 0;
    was_rise = m_rise;
    was_edge = m_rise | m_fall;
    if (was_edge) begin
      if (pend_q.size() == 0 || evtAck) begin
        pend_q.delete();
        pend_q.push_back(was_rise);
        m_evtime = m_ts;
      end else begin
        ovr_set = 1;
      end
    end else if (evtAck && pend_q.size() != 0) begin
      void'(pend_q.pop_front());
    end
    m_ovr  = ovr_set | (m_ovr & ~ovrClr);
    m_rise = 0;
    m_fall = 0;
    if (!en || m_s2 == m_level) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == FILT) begin
        m_level = m_s2;
        m_rise  = m_s2;
        m_fall  = !m_s2;
        m_run   = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = pinIn;
    m_ts = (m_ts + 1) % (1 << TSW);
  endtask

  task automatic compare_all();
    chk("level", level, m_level);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("evtValid", evtValid, pend_q.size() != 0);
    if (pend_q.size() != 0) chk("evtRise", evtRise, pend_q[0]);
    chk("ovr", ovr, m_ovr);
`ifdef PIN_READER_TIMESTAMP_EN
    if (pend_q.size() != 0) chk("evtTime", evtTime, m_evtime);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Ticks until the named pulse appears; returns the number of ticks taken.
  task automatic wait_edge(input bit want_rise, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (want_rise ? rise : fall) return;
    end
    chk(want_rise ? "rise_timeout" : "fall_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int hold;
    rst = 1; pinIn = 1; en = 1; evtAck = 0; ovrClr = 0;

    // Reset with pin high: everything cleared, then level rises 6 cycles after release.
    tick(); tick();
    chk("rst_level", level, 0);
    chk("rst_evtValid", evtValid, 0);
    chk("rst_ovr", ovr, 0);
    rst = 0;
    wait_edge(1'b1, n);
    chk("rst_latency", n, 6);
    chk("rst_level_hi", level, 1);

    // Event appears the following cycle; ack clears it.
    tick();
    chk("evt_valid", evtValid, 1);
    chk("evt_rise", evtRise, 1);
    evtAck = 1; tick(); evtAck = 0;
    chk("ack_clears", evtValid, 0);

    // Glitch: three low synced samples are not enough to flip the level.
    pinIn = 0; tick(); tick(); tick();
    pinIn = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_level", level, 1);
      chk("glitch_fall", fall, 0);
    end

    // Overrun: pending fall, unacked rise sets ovr, pending type unchanged.
    pinIn = 0;
    wait_edge(1'b0, n);
    chk("fall_latency", n, 6);
    tick();
    chk("pend_fall", evtRise, 0);
    pinIn = 1;
    wait_edge(1'b1, n);
    tick();
    chk("ovr_set", ovr, 1);
    chk("ovr_keep_type", evtRise, 0);
    ovrClr = 1; tick(); ovrClr = 0;
    chk("ovr_clr", ovr, 0);

    // Ack on the same cycle a new edge is seen: new event replaces old, no overrun.
    pinIn = 0;
    wait_edge(1'b0, n);
    evtAck = 1; tick(); evtAck = 0;
    chk("ackedge_valid", evtValid, 1);
    chk("ackedge_type", evtRise, 0);
    chk("ackedge_ovr", ovr, 0);

    // en=0 freezes the level even with a long opposite pin value.
    en = 0; pinIn = 1;
    for (int i = 0; i < 12; i++) tick();
    chk("en0_hold", level, 0);
    en = 1;

    // Randomized traffic.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        pinIn = 1'($urandom_range(0, 1));
        hold  = $urandom_range(1, 10);
      end
      hold--;
      rst    = ($urandom_range(0, 299) == 0);
      en     = ($urandom_range(0, 9) != 0);
      evtAck = ($urandom_range(0, 9) < 3);
      ovrClr = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
